// File: rtl/multi_tone_phase_gen.sv
// Multi-channel phase generator feeding a CORDIC sine engine, with decimated
// mixing of the returned sines into a single saturated output sample.
module multi_tone_phase_gen #(
   parameter int unsigned N_CH  = 2,
   parameter int unsigned DIV   = 5,
   parameter int unsigned SHIFT = $clog2(N_CH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ena,
   input  logic                 cfg_we,
   input  logic [2:0]           cfg_ch,
   input  logic [15:0]          cfg_inc,
   output logic                 m_axis_phase_tvalid,
   output logic [16*N_CH-1:0]   m_axis_phase_tdata,
   input  logic                 s_axis_sin_tvalid,
   input  logic [16*N_CH-1:0]   s_axis_sin_tdata,
   output logic                 m_axis_mix_tvalid,
   input  logic                 m_axis_mix_tready,
   output logic [15:0]          m_axis_mix_tdata,
   output logic                 ovf
);

   localparam int unsigned SUM_W  = 16 + $clog2(N_CH);
   localparam int unsigned DCNT_W = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [15:0]              PI_POS    = 16'h6488;
   localparam logic signed [17:0]       PI_POS_S  = 18'sd25736;
   localparam logic signed [17:0]       TWO_PI_S  = 18'sd51472;
   localparam logic [DCNT_W-1:0]        DCNT_LAST = DCNT_W'(DIV - 1);
   localparam logic signed [SUM_W-1:0]  MIX_MAX   = SUM_W'(32767);
   localparam logic signed [SUM_W-1:0]  MIX_MIN   = SUM_W'(-32768);

   logic [15:0]             phase_q [N_CH];
   logic [15:0]             phase_d [N_CH];
   logic [15:0]             inc_q   [N_CH];
   logic [15:0]             inc_d   [N_CH];
   logic signed [17:0]      phase_sum [N_CH];
   logic [15:0]             inc_clamped;

   logic [DCNT_W-1:0]       dcnt_q, dcnt_d;
   logic                    sample_pt;
   logic                    capture;

   logic signed [SUM_W-1:0] sin_sum;
   logic signed [SUM_W-1:0] sin_shift;
   logic [15:0]             mix_sat;

   logic                    phase_tvalid_q;
   logic                    mix_tvalid_q, mix_tvalid_d;
   logic [15:0]             mix_tdata_q, mix_tdata_d;
   logic                    ovf_q, ovf_d;

   assign inc_clamped = (cfg_inc > PI_POS) ? PI_POS : cfg_inc;

   // Increment registers; writes to channels beyond N_CH-1 match no entry.
   always_comb begin
      inc_d = inc_q;
      for (int k = 0; k < int'(N_CH); k++) begin
         if (cfg_we && (cfg_ch == 3'(k))) begin
            inc_d[k] = inc_clamped;
         end
      end
   end

   // Phase step with wrap into [-pi, +pi); sum is 18 bits so it cannot overflow.
   always_comb begin
      phase_d = phase_q;
      for (int k = 0; k < int'(N_CH); k++) begin
         phase_sum[k] = signed'({{2{phase_q[k][15]}}, phase_q[k]}) + signed'({2'b00, inc_q[k]});
         if (ena) begin
            if (phase_sum[k] >= PI_POS_S) begin
               phase_d[k] = 16'(phase_sum[k] - TWO_PI_S);
            end else begin
               phase_d[k] = phase_sum[k][15:0];
            end
         end
      end
   end

   assign sample_pt = ena && (dcnt_q == DCNT_LAST);
   assign capture   = sample_pt && s_axis_sin_tvalid;

   always_comb begin
      dcnt_d = dcnt_q;
      if (ena) begin
         dcnt_d = sample_pt ? '0 : dcnt_q + DCNT_W'(1);
      end
   end

   // Sum of channel sines, scaled and saturated to 16 bits.
   always_comb begin
      sin_sum = '0;
      for (int k = 0; k < int'(N_CH); k++) begin
         sin_sum = sin_sum + SUM_W'(signed'(s_axis_sin_tdata[16*k +: 16]));
      end
      sin_shift = sin_sum >>> SHIFT;
      if (sin_shift > MIX_MAX) begin
         mix_sat = 16'h7FFF;
      end else if (sin_shift < MIX_MIN) begin
         mix_sat = 16'h8000;
      end else begin
         mix_sat = sin_shift[15:0];
      end
   end

   // Output register: a new capture wins over an accept in the same cycle.
   always_comb begin
      mix_tvalid_d = mix_tvalid_q;
      mix_tdata_d  = mix_tdata_q;
      ovf_d        = ovf_q;
      if (capture) begin
         mix_tvalid_d = 1'b1;
         mix_tdata_d  = mix_sat;
         if (mix_tvalid_q && !m_axis_mix_tready) begin
            ovf_d = 1'b1;
         end
      end else if (mix_tvalid_q && m_axis_mix_tready) begin
         mix_tvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < int'(N_CH); k++) begin
            phase_q[k] <= '0;
            inc_q[k]   <= '0;
         end
         dcnt_q         <= '0;
         phase_tvalid_q <= 1'b0;
         mix_tvalid_q   <= 1'b0;
         mix_tdata_q    <= '0;
         ovf_q          <= 1'b0;
      end else begin
         for (int k = 0; k < int'(N_CH); k++) begin
            phase_q[k] <= phase_d[k];
            inc_q[k]   <= inc_d[k];
         end
         dcnt_q         <= dcnt_d;
         phase_tvalid_q <= ena;
         mix_tvalid_q   <= mix_tvalid_d;
         mix_tdata_q    <= mix_tdata_d;
         ovf_q          <= ovf_d;
      end
   end

   for (genvar g = 0; g < int'(N_CH); g++) begin : g_phase_out
      assign m_axis_phase_tdata[16*g +: 16] = phase_q[g];
   end

   assign m_axis_phase_tvalid = phase_tvalid_q;
   assign m_axis_mix_tvalid   = mix_tvalid_q;
   assign m_axis_mix_tdata    = mix_tdata_q;
   assign ovf                 = ovf_q;

endmodule
